cache_mem_arbiter: RTL and testbench
====================================

// Module: cache_mem_arbiter
// PURPOSE
//  Sole owner of the multi-cycle main memory. Arbitrates I-cache miss fills, D-cache miss fills
//  and D-cache write-through stores. Sequences block fills word by word and streams returned words
//  into the granted cache. Sits between the FETCH/MEMORY stage caches and main memory. Its stall
//  outputs (busy, *_done) feed the hazard unit.
// PARAMETERS
//  ADDR_W       16  byte address width
//  DATA_W       16  word width
//  BLOCK_WORDS   8  words per cache block (power of 2); block = 2*BLOCK_WORDS bytes
//  MEM_LAT       4  cycles from mem_en read issue to mem_rvalid for that word
// PORTS
//  clk               in   1       system clock
//  rst_n             in   1       asynchronous active-low reset
//  icache_miss_req   in   1       level; held until icache_fill_done
//  icache_miss_addr  in   ADDR_W  miss address (offset bits ignored)
//  dcache_miss_req   in   1       level; held until dcache_fill_done
//  dcache_miss_addr  in   ADDR_W  miss address (offset bits ignored)
//  dcache_wr_req     in   1       level; held until dcache_wr_ack
//  dcache_wr_addr    in   ADDR_W  store address
//  dcache_wr_data    in   DATA_W  store data
//  mem_en            out  1       memory access this cycle
//  mem_wr            out  1       1 = write, 0 = read (valid with mem_en)
//  mem_addr          out  ADDR_W  memory address
//  mem_wdata         out  DATA_W  write data
//  mem_rdata         in   DATA_W  read data
//  mem_rvalid        in   1       mem_rdata valid (pipelined, in issue order)
//  fill_wr_en        out  1       write fill_data into the selected cache
//  fill_sel          out  1       0 = I-cache, 1 = D-cache
//  fill_word_idx     out  log2(BLOCK_WORDS)  word offset in block
//  fill_data         out  DATA_W  = mem_rdata
//  icache_fill_done  out  1       1-cycle pulse; I block complete
//  dcache_fill_done  out  1       1-cycle pulse; D block complete
//  dcache_wr_ack     out  1       1-cycle pulse; store issued to memory
//  busy              out  1       state != IDLE
// BEHAVIOUR
//  - Reset (async): state=IDLE, counters=0, last_grant=I. All outputs 0.
//  - FSM IDLE -> WRITE | FILL -> DONE -> IDLE.
//  - Grant only in IDLE. Fixed priority: dcache_wr_req > dcache_miss_req > icache_miss_req.
//  - Grant latches the source and the address; later input changes do not affect the operation.
//  - WRITE (1 cycle): mem_en=1, mem_wr=1, latched addr/data; dcache_wr_ack=1; next IDLE.
//  - FILL issue: base = {addr[ADDR_W-1:log2(2*BLOCK_WORDS)], 0}.
//    - Cycles k=0..BLOCK_WORDS-1: mem_en=1, mem_wr=0, mem_addr = base + 2k.
//  - FILL receive: each mem_rvalid drives fill_wr_en=1, fill_data=mem_rdata and
//    fill_word_idx = recv count, then increments the count. Issue and receive overlap.
//  - After the last word is received -> DONE. DONE pulses the selected *_fill_done for 1 cycle.
//  - Fill latency: grant to done = BLOCK_WORDS+MEM_LAT cycles (default 12).
//  - Next grant is earliest the cycle after DONE. No back-to-back grants without a return to IDLE.
//  - Request deasserted mid-fill: fill still completes and done still pulses.
//  - Requests arriving during busy wait. A write waits behind an active fill.
//  - mem_rvalid in IDLE/WRITE: ignored, no fill_wr_en. Simulation assertion fires.
//  - Reset mid-fill: abort immediately; the partial block is the cache's responsibility (valid not set).
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN
//    - Defined: when a D-side request (write or miss) and an I-side request are pending together,
//      grant the side not in last_grant. last_grant updates on every grant.
//      Write still beats D miss within the D side.
//    - Undefined: fixed priority above; last_grant unused.
// STRUCTURE
//  - cache_mem_arb_pkg: arb_state_t {IDLE,WRITE,FILL,DONE}; arb_src_t {SRC_I,SRC_D};
//    defaults for BLOCK_WORDS and MEM_LAT.
//  - Sub-module arb_grant_pick: combinational priority / round-robin picker
//    (requests + last_grant -> grant source, grant type).
//  - Top holds the FSM, issue/receive counters and latched address/data.
// TESTING
//  - I miss addr 0x0046 alone: reads 0x0040..0x004E on cycles 0-7.
//    fill_wr_en idx 0..7 on cycles 4-11; icache_fill_done at cycle 12; fill_sel=0.
//  - dcache_wr_req + dcache_miss_req + icache_miss_req all at once:
//    write (ack, mem_wr=1) -> D fill -> I fill, each separated by one IDLE cycle.
//  - dcache_wr_req rises during an I fill: I fill completes undisturbed;
//    write issues right after the IDLE following DONE.
//  - rst_n low at fill cycle 5: all outputs 0 at once, busy=0.
//    After release, a new I miss starts cleanly with idx 0.
//  - mem_rvalid pulsed while IDLE: no fill_wr_en; assertion reported.
//  - ARB_ROUND_ROBIN_EN, D miss and I miss held continuously: grants alternate D, I, D, I.
//    Without the macro: D, D, D, ...

Source files
------------

// File: rtl/cache_mem_arb_pkg.sv
// Shared types and defaults for the cache/memory arbiter.
// Optional round-robin arbitration is selected with ARB_ROUND_ROBIN_EN.
package cache_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

    localparam int BLOCK_WORDS_DEF = 8;
    localparam int MEM_LAT_DEF     = 4;

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Main-memory bus: the arbiter is the master, the memory is the slave.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport master (
        output mem_en, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_rvalid
    );

    modport slave (
        input  mem_en, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_rvalid
    );
endinterface

// File: rtl/arb_grant_pick.sv
// Combinational grant picker: fixed priority write > D miss > I miss, or
// D/I alternation when ARB_ROUND_ROBIN_EN is defined.
module arb_grant_pick
    import cache_mem_arb_pkg::*;
(
    input  logic     icache_miss_req,
    input  logic     dcache_miss_req,
    input  logic     dcache_wr_req,
`ifdef ARB_ROUND_ROBIN_EN
    input  arb_src_t last_grant,
`endif
    output logic     gnt_valid,
    output arb_src_t gnt_src,
    output logic     gnt_write
);

    logic d_req;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        d_req     = dcache_wr_req | dcache_miss_req;
        gnt_valid = d_req | icache_miss_req;
        gnt_src   = d_req ? SRC_D : SRC_I;
`ifdef ARB_ROUND_ROBIN_EN
        if (d_req && icache_miss_req && (last_grant == SRC_D)) begin
            gnt_src = SRC_I;
        end
`endif
        gnt_write = (gnt_src == SRC_D) && dcache_wr_req;
    end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Owns main memory: serialises D-cache stores and I/D block fills.
// Define ARB_ROUND_ROBIN_EN to alternate D and I grants under contention.
module cache_mem_arbiter
    import cache_mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
    parameter int MEM_LAT     = MEM_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           icache_miss_req,
    input  logic [ADDR_W-1:0]              icache_miss_addr,
    input  logic                           dcache_miss_req,
    input  logic [ADDR_W-1:0]              dcache_miss_addr,
    input  logic                           dcache_wr_req,
    input  logic [ADDR_W-1:0]              dcache_wr_addr,
    input  logic [DATA_W-1:0]              dcache_wr_data,
    cache_mem_arbiter_if.master            mem,
    output logic                           fill_wr_en,
    output logic                           fill_sel,
    output logic [$clog2(BLOCK_WORDS)-1:0] fill_word_idx,
    output logic [DATA_W-1:0]              fill_data,
    output logic                           icache_fill_done,
    output logic                           dcache_fill_done,
    output logic                           dcache_wr_ack,
    output logic                           busy
);

    localparam int IDX_W       = $clog2(BLOCK_WORDS);
    localparam int OFF_W       = $clog2(2 * BLOCK_WORDS);
    localparam int FILL_CYCLES = BLOCK_WORDS + MEM_LAT;
    localparam int AGE_W       = $clog2(FILL_CYCLES + 1);

    arb_state_t        state_q, state_d;
    arb_src_t          src_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W:0]    issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic              issuing;

    logic              gnt_valid, gnt_write;
    arb_src_t          gnt_src;
    logic [ADDR_W-1:0] miss_addr, gnt_addr;

`ifdef ARB_ROUND_ROBIN_EN
    arb_src_t          last_grant;
`endif

    arb_grant_pick u_pick (
        .icache_miss_req (icache_miss_req),
        .dcache_miss_req (dcache_miss_req),
        .dcache_wr_req   (dcache_wr_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant      (last_grant),
`endif
        .gnt_valid       (gnt_valid),
        .gnt_src         (gnt_src),
        .gnt_write       (gnt_write)
    );

    // Fills latch the block base so the issue address is just base + 2k.
    always_comb begin
        miss_addr = (gnt_src == SRC_D) ? dcache_miss_addr : icache_miss_addr;
        gnt_addr  = gnt_write ? dcache_wr_addr
                              : {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (gnt_valid) state_d = gnt_write ? WRITE : FILL;
            WRITE:   state_d = IDLE;
            FILL:    if (fill_wr_en && (recv_cnt == IDX_W'(BLOCK_WORDS - 1))) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issuing          = (state_q == FILL) && (issue_cnt < (IDX_W+1)'(BLOCK_WORDS));
        mem.mem_en       = (state_q == WRITE) || issuing;
        mem.mem_wr       = (state_q == WRITE);
        mem.mem_addr     = '0;
        mem.mem_wdata    = '0;
        if (state_q == WRITE) begin
            mem.mem_addr  = addr_q;
            mem.mem_wdata = data_q;
        end else if (issuing) begin
            mem.mem_addr  = addr_q + ADDR_W'({issue_cnt, 1'b0});
        end
        // Returned words are only meaningful while a fill is in flight.
        fill_wr_en       = (state_q == FILL) && mem.mem_rvalid;
        fill_data        = fill_wr_en ? mem.mem_rdata : '0;
        fill_word_idx    = recv_cnt;
        fill_sel         = ((state_q == FILL) || (state_q == DONE)) && (src_q == SRC_D);
        icache_fill_done = (state_q == DONE) && (src_q == SRC_I);
        dcache_fill_done = (state_q == DONE) && (src_q == SRC_D);
        dcache_wr_ack    = (state_q == WRITE);
        busy             = (state_q != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= SRC_I;
            addr_q     <= '0;
            data_q     <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= SRC_I;
`endif
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && gnt_valid) begin
                src_q      <= gnt_src;
                addr_q     <= gnt_addr;
                data_q     <= dcache_wr_data;
                issue_cnt  <= '0;
                recv_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                last_grant <= gnt_src;
`endif
            end else begin
                if (issuing)    issue_cnt <= issue_cnt + 1'b1;
                if (fill_wr_en) recv_cnt  <= recv_cnt + 1'b1;
            end
        end
    end

    // Simulation-only checks: stray read data and a fill that overruns its latency.
    logic [AGE_W-1:0] fill_age;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                fill_age <= '0;
        else if (state_q == FILL)  fill_age <= fill_age + 1'b1;
        else                       fill_age <= '0;
    end

    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(mem.mem_rvalid && (state_q != FILL)))
                else $warning("cache_mem_arbiter: mem_rvalid outside a fill, word dropped");
            assert ((state_q != FILL) || (fill_age < AGE_W'(FILL_CYCLES)))
                else $error("cache_mem_arbiter: fill exceeded its latency bound");
        end
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with a fixed-latency pipelined memory model.
module tb_cache_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icache_miss_req, dcache_miss_req, dcache_wr_req;
    logic [15:0] icache_miss_addr, dcache_miss_addr, dcache_wr_addr, dcache_wr_data;
    logic        fill_wr_en, fill_sel, icache_fill_done, dcache_fill_done, dcache_wr_ack, busy;
    logic [2:0]  fill_word_idx;
    logic [15:0] fill_data;
    logic        inj_rvalid = 1'b0;

    always #5 clk = ~clk;

    cache_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    cache_mem_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .icache_miss_req  (icache_miss_req),
        .icache_miss_addr (icache_miss_addr),
        .dcache_miss_req  (dcache_miss_req),
        .dcache_miss_addr (dcache_miss_addr),
        .dcache_wr_req    (dcache_wr_req),
        .dcache_wr_addr   (dcache_wr_addr),
        .dcache_wr_data   (dcache_wr_data),
        .mem              (bus.master),
        .fill_wr_en       (fill_wr_en),
        .fill_sel         (fill_sel),
        .fill_word_idx    (fill_word_idx),
        .fill_data        (fill_data),
        .icache_fill_done (icache_fill_done),
        .dcache_fill_done (dcache_fill_done),
        .dcache_wr_ack    (dcache_wr_ack),
        .busy             (busy)
    );

    // Memory: read issued in cycle k returns in cycle k+4; data = addr ^ 0xA5A5.
    logic [3:0]  pv;
    logic [15:0] pa [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
            for (int i = 0; i < 4; i++) pa[i] <= '0;
        end else begin
            pv    <= {pv[2:0], bus.mem_en & ~bus.mem_wr};
            pa[0] <= bus.mem_addr;
            for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
        end
    end

    assign bus.mem_rvalid = pv[3] | inj_rvalid;
    assign bus.mem_rdata  = pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000;

    function automatic logic [15:0] mdat(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    typedef struct {
        int          cyc;
        logic        sel;
        logic [2:0]  idx;
        logic [15:0] data;
    } fill_ev_t;

    fill_ev_t    fills[$];
    int          ack_cyc[$], done_cyc[$], wr_cyc[$];
    logic        done_d[$];
    logic [15:0] wr_addr_log[$];

    int vectors = 0, miscompares = 0, cyc = 0;
    bit auto_drop = 1'b1;
    int t0;
    logic [3:0] exp_order;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        fills.delete(); ack_cyc.delete(); done_cyc.delete();
        wr_cyc.delete(); done_d.delete(); wr_addr_log.delete();
    endtask

    // Advance one cycle, sample #1 after the edge, log events and retire handshakes.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (dcache_wr_ack) begin
            ack_cyc.push_back(cyc);
            if (auto_drop) dcache_wr_req = 1'b0;
        end
        if (dcache_fill_done) begin
            done_cyc.push_back(cyc);
            done_d.push_back(1'b1);
            if (auto_drop) dcache_miss_req = 1'b0;
        end
        if (icache_fill_done) begin
            done_cyc.push_back(cyc);
            done_d.push_back(1'b0);
            if (auto_drop) icache_miss_req = 1'b0;
        end
        if (fill_wr_en) fills.push_back('{cyc, fill_sel, fill_word_idx, fill_data});
        if (bus.mem_en && bus.mem_wr) begin
            wr_cyc.push_back(cyc);
            wr_addr_log.push_back(bus.mem_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        icache_miss_req = 1'b0; dcache_miss_req = 1'b0; dcache_wr_req = 1'b0;
        icache_miss_addr = '0; dcache_miss_addr = '0; dcache_wr_addr = '0; dcache_wr_data = '0;
        step(); step();
        check("rst_busy", busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_fill_we", fill_wr_en, 0);
        check("rst_ack", dcache_wr_ack, 0);
        check("rst_idone", icache_fill_done, 0);
        check("rst_ddone", dcache_fill_done, 0);
        rst_n = 1'b1;
        step();

        // I miss alone at 0x0046: cycle-exact issue, receive and done.
        icache_miss_req = 1'b1; icache_miss_addr = 16'h0046;
        step();
        for (int c = 0; c <= 12; c++) begin
            check("t1_busy", busy, 1);
            check("t1_mem_en", bus.mem_en, (c < 8));
            if (c < 8) begin
                check("t1_rd_addr", bus.mem_addr, 16'h0040 + 2 * c);
                check("t1_mem_wr", bus.mem_wr, 0);
            end
            check("t1_fill_we", fill_wr_en, (c >= 4 && c <= 11));
            if (c >= 4 && c <= 11) begin
                check("t1_idx", fill_word_idx, c - 4);
                check("t1_data", fill_data, mdat(16'h0040 + 16'(2 * (c - 4))));
                check("t1_sel", fill_sel, 0);
            end
            check("t1_idone", icache_fill_done, (c == 12));
            if (c < 12) step();
        end
        step();
        check("t1_idle_busy", busy, 0);
        step();
        check("t1_no_regrant", busy, 0);

        // All three requests at once: write, then D fill, then I fill.
        clear_logs();
        t0 = cyc;
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h1234; dcache_wr_data = 16'hBEEF;
        dcache_miss_req = 1'b1; dcache_miss_addr = 16'h2058;
        icache_miss_req = 1'b1; icache_miss_addr = 16'h30A2;
        step();
        check("t2_ack", dcache_wr_ack, 1);
        check("t2_mem_wr", bus.mem_wr, 1);
        check("t2_mem_en", bus.mem_en, 1);
        check("t2_wr_addr", bus.mem_addr, 16'h1234);
        check("t2_wdata", bus.mem_wdata, 16'hBEEF);
        step();
        check("t2_gap_busy", busy, 0);
        step();
        check("t2_d_addr0", bus.mem_addr, 16'h2050);
        check("t2_d_rd", bus.mem_wr, 0);
        for (int i = 0; i < 60 && done_cyc.size() < 2; i++) step();
        check("t2_done_cnt", done_cyc.size(), 2);
        if (done_cyc.size() == 2) begin
            check("t2_first_is_d", done_d[0], 1);
            check("t2_d_done_cyc", done_cyc[0], t0 + 15);
            check("t2_second_is_i", done_d[1], 0);
            check("t2_i_done_cyc", done_cyc[1], t0 + 29);
        end
        check("t2_fill_cnt", fills.size(), 16);
        if (fills.size() == 16) begin
            check("t2_d_sel", fills[0].sel, 1);
            check("t2_d_data0", fills[0].data, mdat(16'h2050));
            check("t2_i_sel", fills[8].sel, 0);
            check("t2_i_data0", fills[8].data, mdat(16'h30A0));
            check("t2_i_first_cyc", fills[8].cyc, t0 + 21);
        end
        check("t2_ack_cyc", (ack_cyc.size() == 1) ? ack_cyc[0] : -1, t0 + 1);

        // Store arrives mid I fill: waits for DONE plus one IDLE cycle.
        step();
        clear_logs();
        t0 = cyc;
        icache_miss_req = 1'b1; icache_miss_addr = 16'h0102;
        repeat (4) step();
        dcache_wr_req = 1'b1; dcache_wr_addr = 16'h0AAA; dcache_wr_data = 16'h5555;
        for (int i = 0; i < 40 && ack_cyc.size() < 1; i++) step();
        check("t3_done_cyc", (done_cyc.size() == 1) ? done_cyc[0] : -1, t0 + 13);
        check("t3_ack_cyc", (ack_cyc.size() == 1) ? ack_cyc[0] : -1, t0 + 15);
        check("t3_wr_cnt", wr_cyc.size(), 1);
        if (wr_cyc.size() == 1) begin
            check("t3_wr_cyc", wr_cyc[0], t0 + 15);
            check("t3_wr_addr", wr_addr_log[0], 16'h0AAA);
        end
        check("t3_fill_cnt", fills.size(), 8);
        if (fills.size() == 8) begin
            check("t3_last_idx", fills[7].idx, 7);
            check("t3_data0", fills[0].data, mdat(16'h0100));
        end

        // Stray mem_rvalid while IDLE is ignored.
        step();
        check("t5_idle", busy, 0);
        inj_rvalid = 1'b1;
        #1;
        check("t5_no_fill_we", fill_wr_en, 0);
        check("t5_fill_data", fill_data, 0);
        step();
        inj_rvalid = 1'b0;
        check("t5_still_idle", busy, 0);
        check("t5_no_fill_we2", fill_wr_en, 0);

        // Reset at fill cycle 5, then a clean restart.
        clear_logs();
        icache_miss_req = 1'b1; icache_miss_addr = 16'h0046;
        repeat (6) step();
        rst_n = 1'b0;
        icache_miss_req = 1'b0;
        #1;
        check("t4_busy", busy, 0);
        check("t4_mem_en", bus.mem_en, 0);
        check("t4_mem_addr", bus.mem_addr, 0);
        check("t4_fill_we", fill_wr_en, 0);
        check("t4_idx", fill_word_idx, 0);
        check("t4_idone", icache_fill_done, 0);
        step(); step();
        rst_n = 1'b1;
        clear_logs();
        t0 = cyc;
        icache_miss_req = 1'b1; icache_miss_addr = 16'h0080;
        for (int i = 0; i < 30 && done_cyc.size() < 1; i++) step();
        check("t4_fill_cnt", fills.size(), 8);
        if (fills.size() == 8) begin
            check("t4_first_idx", fills[0].idx, 0);
            check("t4_first_cyc", fills[0].cyc, t0 + 5);
            check("t4_first_data", fills[0].data, mdat(16'h0080));
        end
        check("t4_done_cyc", (done_cyc.size() == 1) ? done_cyc[0] : -1, t0 + 13);

        // D and I misses held continuously.
        step();
        clear_logs();
        auto_drop = 1'b0;
        t0 = cyc;
        dcache_miss_req = 1'b1; dcache_miss_addr = 16'h4000;
        icache_miss_req = 1'b1; icache_miss_addr = 16'h5000;
        for (int i = 0; i < 80 && done_cyc.size() < 4; i++) step();
        dcache_miss_req = 1'b0;
        icache_miss_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = 4'b0101;
`else
        exp_order = 4'b1111;
`endif
        check("t6_done_cnt", done_cyc.size(), 4);
        if (done_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check($sformatf("t6_src%0d", k), done_d[k], exp_order[k]);
                check($sformatf("t6_cyc%0d", k), done_cyc[k], t0 + 13 + 14 * k);
            end
        end
        if (fills.size() > 0) check("t6_first_data", fills[0].data, mdat(16'h4000));
        step(); step();
        check("t6_end_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
